// File: rtl/parity_sched_pkg.sv
// parity_sched_pkg: shared types and defaults for the parity scheduler.
// Holds the FSM state enum, default sizes and a pointer wrap helper.
package parity_sched_pkg;

    localparam int NLANES_DEF = 8;
    localparam int ALL_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Next round-robin start position after lane idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/parity_unit.sv
// parity_unit: combinational lane result for the issue stage.
// Result is the parity of the lane's 2-bit operand xor parity of allbits.
module parity_unit #(
    parameter int ALL_W = 8
) (
    input  logic [ALL_W-1:0] allbits,
    input  logic [1:0]       pair,
    output logic             res
);

    assign res = (^pair) ^ (^allbits);

endmodule

// File: rtl/parity_sched.sv
// parity_sched: round-robin grant, one-deep issue stage, registered commit.
// Optional grant counter enabled by defining PARITY_SCHED_STATS_EN.
module parity_sched
    import parity_sched_pkg::*;
#(
    parameter int NLANES = NLANES_DEF,
    parameter int ALL_W  = ALL_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NLANES-1:0]     req,
    input  logic [ALL_W-1:0]      allbits,
    input  logic [2*NLANES-1:0]   onebit,
    output logic [NLANES-1:0]     ack,
    output logic [NLANES-1:0]     bitout,
    output logic                  busy,
    output logic [15:0]           grant_cnt
);

    localparam int PW = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int CW = PW + 1;

    state_t              state;
    state_t              state_nx;
    logic [PW-1:0]       ptr;

    logic [NLANES-1:0]   elig;
    logic                any_elig;
    logic [NLANES-1:0]   grant;
    logic [PW-1:0]       grant_idx;
    logic                found;
    logic [CW-1:0]       cand;
    logic [1:0]          grant_pair;

    logic                stage_valid;
    logic [NLANES-1:0]   stage_lane;
    logic [PW-1:0]       stage_idx;
    logic [ALL_W-1:0]    stage_all;
    logic [1:0]          stage_pair;
    logic                stage_res;

    // A lane in flight (staged or acking) is never granted again.
    assign elig     = req & ~stage_lane & ~ack;
    assign any_elig = |elig;
    assign busy     = (state != IDLE);

    // Round-robin pick: first eligible lane at or above ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        cand      = '0;
        for (int k = 0; k < NLANES; k++) begin
            cand = CW'(ptr) + CW'(k);
            if (cand >= CW'(NLANES)) begin
                cand = cand - CW'(NLANES);
            end
            if (!found && elig[cand[PW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign grant_pair = onebit[{grant_idx, 1'b0} +: 2];

    // Issue-stage result from operands captured at grant.
    parity_unit #(
        .ALL_W (ALL_W)
    ) u_parity (
        .allbits (stage_all),
        .pair    (stage_pair),
        .res     (stage_res)
    );

    // Next-state logic; DRAIN waits for the staged lane to commit.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (any_elig) state_nx = ISSUE;
            end
            ISSUE: begin
                if (!any_elig) state_nx = DRAIN;
            end
            DRAIN: begin
                if (any_elig)         state_nx = ISSUE;
                else if (!stage_valid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            if (found) begin
                ptr <= PW'(wrap_inc(int'(grant_idx), NLANES));
            end
        end
    end

    // Issue stage: holds the granted lane and its operands for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_lane  <= '0;
            stage_idx   <= '0;
            stage_all   <= '0;
            stage_pair  <= '0;
        end else begin
            stage_valid <= found;
            stage_lane  <= grant;
            if (found) begin
                stage_idx  <= grant_idx;
                stage_all  <= allbits;
                stage_pair <= grant_pair;
            end
        end
    end

    // Commit: pulse ack and update only the staged lane's result bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack    <= '0;
            bitout <= '0;
        end else begin
            ack <= stage_lane;
            if (stage_valid) begin
                bitout[stage_idx] <= stage_res;
            end
        end
    end

`ifdef PARITY_SCHED_STATS_EN
    logic [15:0] cnt_q;

    // Saturating count of grants issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (found && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign grant_cnt = cnt_q;
`else
    assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_parity_sched.sv
// tb_parity_sched: directed checks of grant order, latency, commit and reset.
// Grant counter checks follow PARITY_SCHED_STATS_EN when it is defined.
module tb_parity_sched;

    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic [7:0]  allbits;
    logic [15:0] onebit;
    logic [7:0]  ack;
    logic [7:0]  bitout;
    logic        busy;
    logic [15:0] grant_cnt;

    int total;
    int bad;

    parity_sched #(
        .NLANES (8),
        .ALL_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .allbits   (allbits),
        .onebit    (onebit),
        .ack       (ack),
        .bitout    (bitout),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and land on the following negedge to sample.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'hff;
        allbits = 8'hff;
        onebit = 16'hffff;
        repeat (3) step();
        total++;
        if (ack !== 8'h00) begin
            bad++;
            $display("FAIL reset_ack got=%h exp=00", ack);
        end
        total++;
        if (bitout !== 8'h00) begin
            bad++;
            $display("FAIL reset_bitout got=%h exp=00", bitout);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        total++;
        if (grant_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL reset_cnt got=%h exp=0000", grant_cnt);
        end
        req = 8'h00;
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle();
        req = 8'h00;
        for (int i = 0; i < 100; i++) begin
            step();
            total++;
            if (busy !== 1'b0 || ack !== 8'h00 || bitout !== 8'h00) begin
                bad++;
                $display("FAIL idle c=%0d got busy=%b ack=%h bitout=%h exp 0/00/00",
                         i, busy, ack, bitout);
            end
        end
    endtask

    // All lanes request; acks must come out 0..7 on consecutive cycles.
    task automatic run_sweep(input logic [7:0] ab, input logic [15:0] ob,
                             input logic [7:0] expb, input string tag);
        logic [7:0] exp_ack;
        allbits = ab;
        onebit  = ob;
        req     = 8'hff;
        for (int s = 1; s <= 11; s++) begin
            step();
            exp_ack = (s >= 2 && s <= 9) ? 8'(1 << (s - 2)) : 8'h00;
            total++;
            if (ack !== exp_ack) begin
                bad++;
                $display("FAIL %s_ack s=%0d got=%h exp=%h", tag, s, ack, exp_ack);
            end
            if (s == 5) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_busy_on got=%b exp=1", tag, busy);
                end
            end
`ifndef PARITY_SCHED_STATS_EN
            total++;
            if (grant_cnt !== 16'h0000) begin
                bad++;
                $display("FAIL %s_cnt0 got=%h exp=0000", tag, grant_cnt);
            end
`endif
            req = req & ~ack;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_off got=%b exp=0", tag, busy);
        end
        total++;
        if (bitout !== expb) begin
            bad++;
            $display("FAIL %s_bitout got=%h exp=%h", tag, bitout, expb);
        end
    endtask

    task automatic test_sweep_a();
        run_sweep(8'hac, 16'hc01a, 8'h07, "sweep_a");
    endtask

    task automatic test_sweep_b();
        run_sweep(8'hca, 16'h1f01, 8'h41, "sweep_b");
        total++;
        if (bitout[0] !== 1'b1) begin
            bad++;
            $display("FAIL sweep_b_bit0 got=%b exp=1", bitout[0]);
        end
        total++;
        if (bitout[1] !== 1'b0) begin
            bad++;
            $display("FAIL sweep_b_bit1 got=%b exp=0", bitout[1]);
        end
    endtask

    // Lanes 0 and 7 held: grants alternate with 3-cycle per-lane spacing.
    task automatic test_alternate();
        logic [7:0] exp_tab [1:9];
        exp_tab = '{8'h00, 8'h01, 8'h80, 8'h00, 8'h01,
                    8'h80, 8'h00, 8'h01, 8'h80};
        allbits = 8'h00;
        onebit  = 16'h0000;
        req     = 8'h81;
        for (int s = 1; s <= 9; s++) begin
            step();
            total++;
            if (ack !== exp_tab[s]) begin
                bad++;
                $display("FAIL alt_ack s=%0d got=%h exp=%h", s, ack, exp_tab[s]);
            end
        end
        req = 8'h00;
        for (int s = 0; s < 3; s++) begin
            step();
            total++;
            if (ack !== 8'h00) begin
                bad++;
                $display("FAIL alt_tail s=%0d got=%h exp=00", s, ack);
            end
        end
        total++;
        if (bitout !== 8'h40) begin
            bad++;
            $display("FAIL alt_bitout got=%h exp=40", bitout);
        end
    endtask

    // req and operands drop right after grant; commit still uses captured data.
    task automatic test_drop();
        allbits = 8'h01;
        onebit  = 16'h0000;
        req     = 8'h04;
        step();
        req     = 8'h00;
        allbits = 8'h00;
        total++;
        if (ack !== 8'h00) begin
            bad++;
            $display("FAIL drop_ack1 got=%h exp=00", ack);
        end
        step();
        total++;
        if (ack !== 8'h04) begin
            bad++;
            $display("FAIL drop_ack2 got=%h exp=04", ack);
        end
        total++;
        if (bitout !== 8'h44) begin
            bad++;
            $display("FAIL drop_bitout got=%h exp=44", bitout);
        end
        step();
        total++;
        if (ack !== 8'h00) begin
            bad++;
            $display("FAIL drop_ack3 got=%h exp=00", ack);
        end
    endtask

    // Reset lands while lane 3 is staged; it must never ack.
    task automatic test_rst_mid();
        logic [7:0] exp_tab [3:5];
        exp_tab = '{8'h00, 8'h01, 8'h08};
        allbits = 8'h01;
        onebit  = 16'h0000;
        req     = 8'h08;
        step();
        rst = 1'b1;
        step();
        total++;
        if (ack !== 8'h00 || bitout !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_clear got ack=%h bitout=%h busy=%b exp 00/00/0",
                     ack, bitout, busy);
        end
        rst = 1'b0;
        req = 8'h09;
        for (int s = 3; s <= 5; s++) begin
            step();
            total++;
            if (ack !== exp_tab[s]) begin
                bad++;
                $display("FAIL rstmid_ack s=%0d got=%h exp=%h", s, ack, exp_tab[s]);
            end
            req = req & ~ack;
        end
        total++;
        if (bitout !== 8'h09) begin
            bad++;
            $display("FAIL rstmid_bitout got=%h exp=09", bitout);
        end
    endtask

    task automatic test_stats();
        rst = 1'b1;
        req = 8'h00;
        step();
        rst = 1'b0;
        run_sweep(8'hac, 16'hc01a, 8'h07, "stats");
`ifdef PARITY_SCHED_STATS_EN
        total++;
        if (grant_cnt !== 16'd8) begin
            bad++;
            $display("FAIL stats_cnt8 got=%h exp=0008", grant_cnt);
        end
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        req = 8'h07;
        for (int s = 0; s < 6; s++) begin
            step();
            req = req & ~ack;
        end
        total++;
        if (grant_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL stats_sat got=%h exp=ffff", grant_cnt);
        end
`else
        total++;
        if (grant_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL stats_off got=%h exp=0000", grant_cnt);
        end
`endif
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        req     = 8'h00;
        allbits = 8'h00;
        onebit  = 16'h0000;
        @(negedge clk);
        test_reset();
        test_idle();
        test_sweep_a();
        test_sweep_b();
        test_alternate();
        test_drop();
        test_rst_mid();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
